urv_mem_responder: RTL and testbench

URV_MEM_RESPONDER -- requirements
Module: urv_mem_responder

---
 rtl/urv_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_urv_mem_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/urv_mem_responder.sv
// Single-port-style memory responder for a uRV-class core.
// Instruction port: registered read, one cycle after the address.
// Data port: IDLE/WAIT/DONE handshake FSM with byte-lane stores.
// Optional build macro URV_MEM_WAITSTATE_EN inserts g_wait_states extra
// cycles per data access; without it the data port never stalls.
module urv_mem_responder #(
  parameter int unsigned g_size_words  = 16384,
  parameter int unsigned g_wait_states = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o
);

  localparam int unsigned AW = (g_size_words > 1) ? $clog2(g_size_words) : 1;
  localparam int unsigned CW = $clog2(g_wait_states + 2);

`ifdef URV_MEM_WAITSTATE_EN
  localparam logic [CW-1:0] WaitLoad = CW'(g_wait_states);
`else
  localparam logic [CW-1:0] WaitLoad = '0;
`endif

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      sel_q;
  logic            store_q;

  logic [31:0]     mem [g_size_words];
  logic [31:0]     im_data_q;
  logic            im_valid_q;
  logic [31:0]     ldata_q;

  logic            accept;
  logic            access;
  logic            in_wait;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic [3:0]      acc_sel;
  logic            acc_store;

  // Request acceptance; a request seen while reset is held is never taken.
  always_comb begin
    in_wait    = (state_q == StWait);
    dm_ready_o = ~in_wait;
    accept     = (dm_load_i | dm_store_i) & ~in_wait & ~rst_i;
  end

  // Next-state logic; 'access' marks the edge that enters DONE, where memory is touched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (WaitLoad == '0) begin
            state_d = StDone;
            cnt_d   = '0;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q <= CW'(1)) begin
          state_d = StDone;
          cnt_d   = '0;
          access  = ~rst_i;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Zero-wait accesses use the live request; delayed ones use the latched copy.
  always_comb begin
    if (in_wait) begin
      acc_idx   = addr_q;
      acc_wdata = wdata_q;
      acc_sel   = sel_q;
      acc_store = store_q;
    end else begin
      acc_idx   = dm_addr_i[AW+1:2];
      acc_wdata = dm_data_s_i;
      acc_sel   = dm_data_select_i;
      acc_store = dm_store_i;
    end
  end

  // FSM state, wait counter and latched request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= dm_addr_i[AW+1:2];
        wdata_q <= dm_data_s_i;
        sel_q   <= dm_data_select_i;
        // Simultaneous load and store is treated as a store.
        store_q <= dm_store_i;
      end
    end
  end

  // Memory array write with byte-lane enables; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (access && acc_store) begin
      for (int n = 0; n < 4; n++) begin
        if (acc_sel[n]) begin
          mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
        end
      end
    end
  end

  // Registered instruction fetch (old data on a same-edge store) and load data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      im_data_q  <= '0;
      im_valid_q <= 1'b0;
      ldata_q    <= '0;
    end else begin
      im_data_q  <= mem[im_addr_i[AW+1:2]];
      im_valid_q <= 1'b1;
      if (access && !acc_store) begin
        ldata_q <= mem[acc_idx];
      end
    end
  end

  // Done pulses last exactly the single DONE cycle of each access.
  always_comb begin
    im_data_o       = im_data_q;
    im_valid_o      = im_valid_q;
    dm_data_l_o     = ldata_q;
    dm_store_done_o = (state_q == StDone) & store_q;
    dm_load_done_o  = (state_q == StDone) & ~store_q;
  end

endmodule

// File: tb/tb_urv_mem_responder.sv
// Scoreboard bench for urv_mem_responder: a word-array reference model
// predicts every fetch word, done pulse and load value; a monitor compares.
module tb_urv_mem_responder;

  localparam int unsigned Size = 1024;
`ifdef URV_MEM_WAITSTATE_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] im_addr = '0;
  logic [31:0] im_data;
  logic        im_valid;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [3:0]  dm_sel = '0;
  logic        dm_store = 1'b0;
  logic        dm_load = 1'b0;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        ld_done;
  logic        st_done;

  always #5 clk = ~clk;

  urv_mem_responder #(.g_size_words(Size), .g_wait_states(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_wdata), .dm_data_select_i(dm_sel),
    .dm_store_i(dm_store), .dm_load_i(dm_load), .dm_ready_o(dm_ready),
    .dm_data_l_o(dm_rdata), .dm_load_done_o(ld_done), .dm_store_done_o(st_done)
  );

  typedef struct {bit is_store; logic [31:0] data; bit known;} done_t;
  typedef struct {logic [31:0] data; bit known;} im_t;

  logic [31:0] mmem [Size];
  bit          known [Size];
  done_t       dq[$];
  im_t         iq[$];
  bit          m_pend = 0;
  int          m_rem = 0;
  bit          m_st;
  int          m_idx;
  logic [31:0] m_wd;
  logic [3:0]  m_sel;
  bit          m_imv = 0;
  logic [31:0] m_last = '0;
  bit          m_last_known = 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference memory access: a store merges enabled bytes, a load returns the word.
  task automatic perform(bit st, int idx, logic [31:0] d, logic [3:0] sel);
    if (st) begin
      for (int n = 0; n < 4; n++)
        if (sel[n]) mmem[idx][8*n +: 8] = d[8*n +: 8];
      if (sel == 4'hF) known[idx] = 1;
      dq.push_back('{is_store: 1, data: '0, known: 0});
    end else begin
      dq.push_back('{is_store: 0, data: mmem[idx], known: known[idx]});
      m_last = mmem[idx];
      m_last_known = known[idx];
    end
  endtask

  // Model: per edge, fetch sees pre-store memory; access lands W edges after accept.
  initial begin
    int ix;
    forever begin
      @(posedge clk);
      if (!rst) begin
        ix = int'(im_addr[11:2]);
        iq.push_back('{data: mmem[ix], known: known[ix]});
        m_imv = 1;
        if (m_pend) begin
          m_rem--;
          if (m_rem == 0) begin
            perform(m_st, m_idx, m_wd, m_sel);
            m_pend = 0;
          end
        end else if (dm_load || dm_store) begin
          if (W == 0) begin
            perform(dm_store, int'(dm_addr[11:2]), dm_wdata, dm_sel);
          end else begin
            m_pend = 1;
            m_rem  = W;
            m_st   = dm_store;
            m_idx  = int'(dm_addr[11:2]);
            m_wd   = dm_wdata;
            m_sel  = dm_sel;
          end
        end
      end
    end
  end

  // Monitor: compare DUT outputs against model predictions shortly after each edge.
  initial begin
    im_t   ie;
    done_t de;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        chk("rst_ready", {31'd0, dm_ready}, 32'd1);
        chk("rst_im_valid", {31'd0, im_valid}, 32'd0);
        chk("rst_im_data", im_data, 32'd0);
        chk("rst_load_data", dm_rdata, 32'd0);
        chk("rst_done", {30'd0, ld_done, st_done}, 32'd0);
      end else begin
        chk("ready", {31'd0, dm_ready}, {31'd0, !m_pend});
        chk("im_valid", {31'd0, im_valid}, {31'd0, m_imv});
        if (im_valid) begin
          chk("im_queue", iq.size(), 32'd1);
          if (iq.size() > 0) begin
            ie = iq.pop_front();
            if (ie.known) chk("im_data", im_data, ie.data);
          end
        end
        chk("done_count", dq.size(), {31'd0, ld_done | st_done});
        if (dq.size() > 0) begin
          de = dq.pop_front();
          if (ld_done | st_done) begin
            chk("done_both", {31'd0, ld_done & st_done}, 32'd0);
            chk("done_type", {31'd0, st_done}, {31'd0, de.is_store});
            if (!de.is_store && de.known) chk("load_data", dm_rdata, de.data);
          end
        end
        if (m_last_known) chk("load_hold", dm_rdata, m_last);
      end
    end
  end

  task automatic do_reset(int cycles);
    #2;
    rst = 1'b1;
    dq.delete();
    iq.delete();
    m_pend = 0;
    m_imv = 0;
    m_last = '0;
    m_last_known = 1;
    #1;
    chk("reset_ready_now", {31'd0, dm_ready}, 32'd1);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Present a request once the model says the port is ready; returns just after accept.
  task automatic issue(bit ld, bit st, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                       logic [31:0] ia);
    int n = 0;
    @(negedge clk);
    while (m_pend && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready_timeout", {31'd0, m_pend}, 32'd0);
    dm_load = ld; dm_store = st; dm_addr = a; dm_wdata = d; dm_sel = s; im_addr = ia;
    @(posedge clk);
    #1;
    dm_load = 1'b0;
    dm_store = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!(ld_done | st_done) && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_timeout", {31'd0, ld_done | st_done}, 32'd1);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < Size; i++) begin
      mmem[i] = '0;
      known[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Fill every word (high address bits random to exercise wrap).
    for (int i = 0; i < Size; i++)
      issue(0, 1, {$urandom_range(0, 1023), 12'd0} | (i * 4) | $urandom_range(0, 3),
            $urandom, 4'hF, $urandom);

    issue(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 32'h0);
    wait_done(cyc);
    chk("store_done_first", {31'd0, st_done}, 32'd1);
    issue(1, 0, 32'h100, 32'h0, 4'h0, 32'h0);
    wait_done(cyc);
    chk("load_latency", cyc, W + 1);
    chk("load_deadbeef", dm_rdata, 32'hDEADBEEF);

    issue(0, 1, 32'h104, 32'h11223344, 4'hF, 32'h0);
    issue(0, 1, 32'h104, 32'h000000AA, 4'b0001, 32'h0);
    issue(0, 1, 32'h104, 32'hFFFFFFFF, 4'b0000, 32'h0);
    issue(1, 1, 32'h104, 32'h55555555, 4'b0000, 32'h0);
    issue(1, 0, 32'h104, 32'h0, 4'h0, 32'h0);
    wait_done(cyc);
    chk("byte_lane_merge", dm_rdata, 32'h112233AA);

    issue(0, 1, 32'h1000, 32'h5, 4'hF, 32'h0);
    issue(1, 0, 32'h0, 32'h0, 4'hF, 32'h0);
    wait_done(cyc);
    chk("addr_wrap", dm_rdata, 32'h5);

    issue(0, 1, 32'h300, 32'h13, 4'hF, 32'h0);
    issue(0, 1, 32'h300, 32'hCAFEF00D, 4'hF, 32'h300);
    wait_done(cyc);
    chk("fetch_old_word", im_data, 32'h13);
    @(posedge clk);
    #1;
    chk("fetch_new_word", im_data, 32'hCAFEF00D);

    issue(0, 1, 32'h200, 32'h12345678, 4'hF, 32'h0);
    do_reset(2);
    issue(1, 0, 32'h200, 32'h0, 4'hF, 32'h200);
    wait_done(cyc);

    // Random traffic, including requests while busy and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      dm_load  = ($urandom_range(0, 2) == 0);
      dm_store = ($urandom_range(0, 2) == 0);
      dm_addr  = $urandom;
      dm_wdata = $urandom;
      dm_sel   = 4'($urandom);
      im_addr  = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset(1 + $urandom_range(0, 2));
    end
    @(negedge clk);
    dm_load = 1'b0;
    dm_store = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
